// File: rtl/alu_pkg.sv
// Shared opcode and state types for the sequential ALU.
package alu_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLT = 3'd5,
        OP_MUL = 3'd6,
        OP_DIV = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between decode, the ALU and writeback.
interface alu_seq_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [OP_W-1:0]  Op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] ResultHi;
    logic             Zero;
    logic             Cout;
    logic             Overflow;
    logic             DivZero;

    modport master (
        output in_valid, A, B, Op, out_ready,
        input  in_ready, out_valid, Result, ResultHi, Zero, Cout, Overflow, DivZero
    );

    modport slave (
        input  in_valid, A, B, Op, out_ready,
        output in_ready, out_valid, Result, ResultHi, Zero, Cout, Overflow, DivZero
    );
endinterface

// File: rtl/alu_seq_muldiv_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// Latency WIDTH cycles after start; done flags the final step, lo/hi carry that step's result.
module seq_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             is_div_q, is_div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] hi_step;
    logic [WIDTH-1:0] lo_step;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // MUL: {hi,lo} shifts right, hi accumulates b when the multiplier LSB is set.
    // DIV: remainder in hi, dividend shifts out of lo while quotient bits shift in.
    always_comb begin
        hi_step = hi_q;
        lo_step = lo_q;
        add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        shifted = {hi_q, lo_q[WIDTH-1]};
        diff    = shifted - {1'b0, b_q};
        if (is_div_q) begin
            if (!diff[WIDTH]) begin
                hi_step = diff[WIDTH-1:0];
                lo_step = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_step = shifted[WIDTH-1:0];
                lo_step = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_step = add_sum[WIDTH:1];
            lo_step = {add_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        is_div_d = is_div_q;
        cnt_d    = cnt_q;
        if (start) begin
            hi_d     = '0;
            lo_d     = a;
            b_d      = b;
            is_div_d = is_div;
            cnt_d    = CNT_W'(WIDTH);
        end else if (cnt_q != '0) begin
            hi_d  = hi_step;
            lo_d  = lo_step;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            is_div_q <= is_div_d;
            cnt_q    <= cnt_d;
        end
    end

    assign done = (cnt_q == CNT_W'(1));
    assign lo   = lo_step;
    assign hi   = hi_step;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops and DIV-by-zero in 1 cycle, MUL/DIV in WIDTH+1 cycles.
// Result held in DONE until out_ready; in_ready only in IDLE, so issue interval is >= 2 cycles.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             zero_q, zero_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             divz_q, divz_d;

    op_t              op;
    logic             accept;
    logic             is_iter;
    logic             mdu_start;
    logic             mdu_done;
    logic [WIDTH-1:0] mdu_lo;
    logic [WIDTH-1:0] mdu_hi;

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sc_res;
    logic [WIDTH-1:0] sc_hi;
    logic             sc_cout;
    logic             sc_ovf;
    logic             sc_divz;

    assign op        = op_t'(bus.Op);
    assign accept    = bus.in_valid && (state_q == ST_IDLE);
    assign is_iter   = (op == OP_MUL) || ((op == OP_DIV) && (bus.B != '0));
    assign mdu_start = accept && is_iter;

    seq_muldiv_unit #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (mdu_start),
        .is_div (op == OP_DIV),
        .a      (bus.A),
        .b      (bus.B),
        .done   (mdu_done),
        .lo     (mdu_lo),
        .hi     (mdu_hi)
    );

    // SUB reuses the adder as A + ~B + 1, so Cout=1 means no borrow.
    always_comb begin
        sc_res  = '0;
        sc_hi   = '0;
        sc_cout = 1'b0;
        sc_ovf  = 1'b0;
        sc_divz = 1'b0;
        is_sub  = (op == OP_SUB);
        b_eff   = is_sub ? ~bus.B : bus.B;
        sum     = {1'b0, bus.A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        case (op)
            OP_ADD, OP_SUB: begin
                sc_res  = sum[WIDTH-1:0];
                sc_cout = sum[WIDTH];
                sc_ovf  = (bus.A[WIDTH-1] == b_eff[WIDTH-1]) &&
                          (sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_AND: sc_res = bus.A & bus.B;
            OP_OR:  sc_res = bus.A | bus.B;
            OP_XOR: sc_res = bus.A ^ bus.B;
            OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            OP_DIV: begin
                sc_res  = '1;
                sc_hi   = bus.A;
                sc_divz = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        divz_d      = divz_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d = op;
                    if (is_iter) begin
                        state_d = ST_BUSY;
                    end else begin
                        state_d     = ST_DONE;
                        result_d    = sc_res;
                        result_hi_d = sc_hi;
                        zero_d      = (sc_res == '0);
                        cout_d      = sc_cout;
                        ovf_d       = sc_ovf;
                        divz_d      = sc_divz;
                    end
                end
            end
            ST_BUSY: begin
                if (mdu_done) begin
                    state_d     = ST_DONE;
                    result_d    = mdu_lo;
                    result_hi_d = mdu_hi;
                    zero_d      = (mdu_lo == '0);
                    cout_d      = (op_q == OP_MUL) && (mdu_hi != '0);
                    ovf_d       = 1'b0;
                    divz_d      = 1'b0;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_ADD;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b1;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            divz_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            divz_q      <= divz_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.Result    = result_q;
    assign bus.ResultHi  = result_hi_q;
    assign bus.Zero      = zero_q;
    assign bus.Cout      = cout_q;
    assign bus.Overflow  = ovf_q;
    assign bus.DivZero   = divz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed checks of alu_seq at WIDTH=32 and WIDTH=8 against an arithmetic model.
module tb_alu_seq;

    logic clk;
    logic rst32;
    logic rst8;

    int n_checks = 0;
    int n_errors = 0;

    alu_seq_if #(.WIDTH(32)) if32 ();
    alu_seq_if #(.WIDTH(8))  if8  ();

    alu_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst32), .bus(if32));
    alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst8),  .bus(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic        z, c, v, dz;
        int          lat;
    } exp_t;

    typedef struct {
        logic        in_ready;
        logic        out_valid;
        logic [31:0] res;
        logic [31:0] hi;
        logic        z, c, v, dz;
    } obs_t;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic over w-bit operands.
    function automatic exp_t model(input int w, input logic [2:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint unsigned mask, ua, ub, p;
        longint sa, sb, s, lim;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        lim  = longint'(64'd1 << (w - 1));
        sa   = longint'(ua);
        sb   = longint'(ub);
        if (sa >= lim) sa = sa - 2 * lim;
        if (sb >= lim) sb = sb - 2 * lim;
        e.res = '0; e.hi = '0; e.c = 1'b0; e.v = 1'b0; e.dz = 1'b0;
        case (op)
            3'd0: begin
                p = ua + ub;
                e.res = 32'(p & mask);
                e.c = ((p >> w) != 0);
                s = sa + sb;
                e.v = (s >= lim) || (s < -lim);
            end
            3'd1: begin
                p = (ua - ub) & mask;
                e.res = 32'(p);
                e.c = (ua >= ub);
                s = sa - sb;
                e.v = (s >= lim) || (s < -lim);
            end
            3'd2: e.res = 32'(ua & ub);
            3'd3: e.res = 32'(ua | ub);
            3'd4: e.res = 32'(ua ^ ub);
            3'd5: e.res = (sa < sb) ? 32'd1 : 32'd0;
            3'd6: begin
                p = ua * ub;
                e.res = 32'(p & mask);
                e.hi = 32'(p >> w);
                e.c = (e.hi != 0);
            end
            default: begin
                if (ub == 0) begin
                    e.res = 32'(mask);
                    e.hi = 32'(ua);
                    e.dz = 1'b1;
                end else begin
                    e.res = 32'(ua / ub);
                    e.hi = 32'(ua % ub);
                end
            end
        endcase
        e.z   = (e.res == 0);
        e.lat = ((op == 3'd6) || (op == 3'd7 && ub != 0)) ? w + 1 : 1;
        return e;
    endfunction

    task automatic drive(input bit w8, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic ordy);
        if (w8) begin
            if8.in_valid = v; if8.A = a[7:0]; if8.B = b[7:0]; if8.Op = op; if8.out_ready = ordy;
        end else begin
            if32.in_valid = v; if32.A = a; if32.B = b; if32.Op = op; if32.out_ready = ordy;
        end
    endtask

    task automatic sample(input bit w8, output obs_t o);
        if (w8) begin
            o.in_ready = if8.in_ready; o.out_valid = if8.out_valid;
            o.res = 32'(if8.Result); o.hi = 32'(if8.ResultHi);
            o.z = if8.Zero; o.c = if8.Cout; o.v = if8.Overflow; o.dz = if8.DivZero;
        end else begin
            o.in_ready = if32.in_ready; o.out_valid = if32.out_valid;
            o.res = if32.Result; o.hi = if32.ResultHi;
            o.z = if32.Zero; o.c = if32.Cout; o.v = if32.Overflow; o.dz = if32.DivZero;
        end
    endtask

    task automatic do_op(input bit w8, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int hold, output obs_t got);
        exp_t e;
        obs_t o;
        int lat;
        e = model(w8 ? 8 : 32, op, a, b);
        @(negedge clk);
        drive(w8, 1'b1, a, b, op, 1'b0);
        sample(w8, o);
        check("in_ready_idle", 128'(o.in_ready), 128'(1));
        @(negedge clk);
        drive(w8, 1'b0, $urandom, $urandom, 3'($urandom), 1'b0);
        sample(w8, o);
        lat = 1;
        check("in_ready_after_accept", 128'(o.in_ready), 128'(0));
        while (!o.out_valid && lat < 200) begin
            drive(w8, 1'($urandom), $urandom, $urandom, 3'($urandom), 1'b0);
            @(negedge clk);
            lat++;
            sample(w8, o);
        end
        check("latency", 128'(lat), 128'(e.lat));
        check("result", 128'(o.res), 128'(e.res));
        check("result_hi", 128'(o.hi), 128'(e.hi));
        check("flags_zcvd", 128'({o.z, o.c, o.v, o.dz}), 128'({e.z, e.c, e.v, e.dz}));
        got = o;
        for (int i = 0; i < hold; i++) begin
            drive(w8, 1'($urandom), $urandom, $urandom, 3'($urandom), 1'b0);
            @(negedge clk);
            sample(w8, o);
            check("hold_stable", {58'd0, o.out_valid, o.in_ready, o.res, o.hi, o.z, o.c, o.v, o.dz},
                  {58'd0, 1'b1, 1'b0, e.res, e.hi, e.z, e.c, e.v, e.dz});
        end
        drive(w8, 1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
        @(negedge clk);
        sample(w8, o);
        check("release_to_idle", 128'({o.out_valid, o.in_ready}), 128'(2'b01));
        drive(w8, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        int vcnt;
        rst32 = 1'b1;
        rst8  = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
        drive(1'b1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
        repeat (3) @(negedge clk);
        rst32 = 1'b0;
        rst8  = 1'b0;
        @(negedge clk);

        sample(1'b0, o);
        check("reset32_ctrl_flags", 128'({o.in_ready, o.out_valid, o.z, o.c, o.v, o.dz}), 128'(6'b101000));
        check("reset32_result", 128'({o.res, o.hi}), 128'(0));
        sample(1'b1, o);
        check("reset8_ctrl_flags", 128'({o.in_ready, o.out_valid, o.z, o.c, o.v, o.dz}), 128'(6'b101000));

        do_op(1'b0, 3'd0, 32'hFFFF_FFFF, 32'd1, 0, o);
        check("add_wrap_literal", 128'({o.res, o.z, o.c, o.v}), 128'({32'd0, 1'b1, 1'b1, 1'b0}));
        do_op(1'b0, 3'd1, 32'h8000_0000, 32'd1, 0, o);
        check("sub_ovf_literal", 128'({o.res, o.v, o.c}), 128'({32'h7FFF_FFFF, 1'b1, 1'b1}));
        do_op(1'b0, 3'd5, 32'hFFFF_FFFF, 32'd1, 0, o);
        check("slt_literal", 128'(o.res), 128'(1));
        do_op(1'b0, 3'd6, 32'hFFFF_FFFF, 32'd2, 0, o);
        check("mul_literal", 128'({o.hi, o.res, o.c}), 128'({32'd1, 32'hFFFF_FFFE, 1'b1}));
        do_op(1'b0, 3'd7, 32'd100, 32'd7, 0, o);
        check("div_literal", 128'({o.res, o.hi, o.dz}), 128'({32'd14, 32'd2, 1'b0}));
        do_op(1'b0, 3'd7, 32'd5, 32'd0, 10, o);
        check("divzero_literal", 128'({o.res, o.hi, o.dz}), 128'({32'hFFFF_FFFF, 32'd5, 1'b1}));
        do_op(1'b1, 3'd6, 32'hFF, 32'hFF, 3, o);
        check("mul8_literal", 128'({o.hi, o.res}), 128'({32'hFE, 32'h01}));

        // Reset in the middle of a multiply must abandon it silently.
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 3'd6, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
        repeat (9) @(negedge clk);
        rst32 = 1'b1;
        @(negedge clk);
        rst32 = 1'b0;
        sample(1'b0, o);
        check("mid_reset_idle", 128'({o.in_ready, o.out_valid}), 128'(2'b10));
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if32.out_valid) vcnt++;
        end
        check("mid_reset_no_valid", 128'(vcnt), 128'(0));
        do_op(1'b0, 3'd0, 32'd3, 32'd4, 0, o);
        check("post_reset_add", 128'(o.res), 128'(7));

        for (int i = 0; i < 60; i++) begin
            do_op(1'b0, 3'($urandom), pick(), pick(), $urandom_range(0, 3), o);
        end
        for (int i = 0; i < 40; i++) begin
            do_op(1'b1, 3'($urandom), $urandom, ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom,
                  $urandom_range(0, 2), o);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor to the combinational 32-bit ALU.
- Registers operands on accept.
- Executes single-cycle logic/arithmetic ops in one cycle.
- Executes unsigned multiply and divide iteratively, one bit per cycle.
- Holds the result until the consumer takes it.
- Sits between the decode stage and writeback; backpressure flows through valid/ready.

Parameters:
WIDTH, 32, operand/result width in bits (>= 2).
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
clk  input  1  clock.
rst  input  1  reset. Synchronous, active-high, sampled on rising clk.
in_valid  input  1  operands and Op are valid.
in_ready  output  1  block can accept (high only in IDLE).
A  input  WIDTH  operand A.
B  input  WIDTH  operand B.
Op  input  3  operation code (alu_pkg).
out_valid  output  1  result registers valid.
out_ready  input  1  consumer takes the result.
Result  output  WIDTH  primary result (low product / quotient).
ResultHi  output  WIDTH  high product / remainder; 0 for other ops.
Zero  output  1  Result == 0.
Cout  output  1  carry out (ADD/SUB); |ResultHi for MUL; 0 otherwise.
Overflow  output  1  signed overflow (ADD/SUB only).
DivZero  output  1  DIV with B == 0.

Behaviour:
- Op encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 MUL (unsigned), 7 DIV (unsigned). All 8 codes are legal.
- States:
  - IDLE: in_ready=1.
  - BUSY: MUL/DIV iterating, in_ready=0.
  - DONE: out_valid=1, in_ready=0.
- IDLE -> accept when in_valid && in_ready. A, B, Op are latched; later input changes are ignored until the next IDLE.
- Single-cycle ops, and DIV with B==0: result computed from the input ports, registered, go to DONE. out_valid rises the cycle after accept (latency 1).
- MUL/DIV with B!=0: go to BUSY, counter=WIDTH.
  - One shift-add (MUL) or restoring-subtract (DIV) step per cycle; counter decrements.
  - On the step where counter==1, go to DONE.
  - out_valid rises WIDTH+1 cycles after the accept edge.
- DONE: all outputs stay stable while out_ready=0. When out_ready=1, go to IDLE and drop out_valid next cycle.
  - No accept in the same cycle as DONE exit: minimum issue interval is 2 cycles.
- Arithmetic:
  - ADD: {Cout,Result}=A+B.
  - SUB: A+~B+1; Cout=1 means no borrow (A>=B unsigned).
  - Overflow uses two's-complement sign rule; it is 0 for non-ADD/SUB ops.
  - SLT: Result=1 if $signed(A)<$signed(B), else 0.
  - MUL: {ResultHi,Result}=A*B, full 2*WIDTH product.
  - DIV: Result=A/B, ResultHi=A%B.
  - DIV by zero: Result=all ones, ResultHi=A, DivZero=1.
  - Zero evaluates Result only, never ResultHi.
- Reset: state=IDLE, counter=0. out_valid=0, Result/ResultHi=0, Zero=1, Cout=Overflow=DivZero=0. in_ready is 1 after reset.
- Reset during BUSY or DONE discards the operation; no out_valid pulse follows.
- Flags are registered together with Result. No combinational path from A/B/Op to any output.

Decomposition:
- alu_pkg:
  - op_t enum (the 8 codes).
  - state_t enum (IDLE, BUSY, DONE).
  - OP_W=3 constant.
- Sub-module seq_muldiv_unit #(WIDTH):
  - Holds the iterative MUL/DIV datapath, partial product/remainder registers and counter.
  - Ports: start, is_div, a, b, done, lo, hi.
- Top-level alu_seq contains the FSM, the single-cycle ops and the output registers.

Test Plan:
- Reset, then idle → in_ready=1, out_valid=0, Zero=1, all other outputs 0.
- ADD A=0xFFFFFFFF, B=1 → next cycle out_valid=1, Result=0, Zero=1, Cout=1, Overflow=0. SUB A=0x80000000, B=1 → Result=0x7FFFFFFF, Overflow=1, Cout=1.
- SLT A=0xFFFFFFFF, B=1 → Result=1. MUL A=0xFFFFFFFF, B=2 → out_valid exactly 33 cycles after accept, ResultHi=1, Result=0xFFFFFFFE, Cout=1.
- DIV A=100, B=7 → Result=14, ResultHi=2, DivZero=0 after 33 cycles. DIV A=5, B=0 → 1-cycle latency, Result=0xFFFFFFFF, ResultHi=5, DivZero=1.
- Hold out_ready=0 for 10 cycles after DONE while toggling A/B/in_valid → outputs stable, in_ready=0, no new accept. Then out_ready=1 → IDLE.
- Assert rst mid-MUL (cycle 10) → next cycle IDLE, out_valid stays 0, next ADD 3+4 returns Result=7. Repeat with WIDTH=8: MUL 0xFF*0xFF → hi=0xFE, lo=0x01, latency 9.
